// File: rtl/prince_affine_share_stage_pkg.sv
// Shared definitions for the masked PRINCE affine share stage.
//   DEF_SHARES / DEF_WIDTH : default share count and per-share state width
//   NIBBLES                : nibbles per share at the default width
//   AFFINE_CONST           : complement mask, applied to share 0 only
//   share_slice()          : extracts one share from a packed shared state
package prince_ti_pkg;

  localparam int DEF_SHARES = 5;
  localparam int DEF_WIDTH  = 64;
  localparam int NIBBLES    = DEF_WIDTH / 4;

  localparam logic [3:0] AFFINE_CONST = 4'b0101;

  typedef logic [DEF_WIDTH-1:0]            share_t;
  typedef logic [DEF_SHARES*DEF_WIDTH-1:0] state_t;

  function automatic share_t share_slice(input state_t bus, input int unsigned s);
    return bus[s*DEF_WIDTH +: DEF_WIDTH];
  endfunction

endpackage

// File: rtl/prince_affine_share_stage_if.sv
// Valid/ready stream carrying one fully shared state.
//   valid  : producer presents a shared state
//   ready  : consumer accepts
//   shares : share s at bits [s*WIDTH +: WIDTH]
// master = producer side, slave = consumer side.
interface prince_affine_share_stage_if
  import prince_ti_pkg::*;
#(
  parameter int DW = DEF_SHARES * DEF_WIDTH
);

  logic          valid;
  logic          ready;
  logic [DW-1:0] shares;

  modport master (output valid, output shares, input ready);
  modport slave  (input valid, input shares, output ready);

endinterface

// File: rtl/prince_affine_share_stage_nibble.sv
// PRINCE S-box output affine map on one nibble of one share.
//   x : input nibble
//   z : z0 = x1^c, z1 = x0^x1^x2, z2 = x3^c, z3 = x2
// COMPLEMENT selects c = 1; it is set for share 0 only, so the constant
// enters the unshared value exactly once.
module prince_affine_nibble
  import prince_ti_pkg::*;
#(
  parameter bit COMPLEMENT = 1'b0
) (
  input  logic [3:0] x,
  output logic [3:0] z
);

  localparam logic [3:0] MASK = COMPLEMENT ? AFFINE_CONST : 4'b0000;

  assign z = {x[2], x[3], x[0] ^ x[1] ^ x[2], x[1]} ^ MASK;

endmodule

// File: rtl/prince_affine_share_stage.sv
// Elastic, registered affine stage between the masked S-box core and the
// linear layer. Shares are transformed independently on capture and stored
// in a 2-entry main/skid buffer, so out_shares comes straight from flops and
// no combinational path mixes shares.
//   clk, rst   : clock, synchronous active-high reset
//   flush      : synchronous drop of all buffered content
//   up         : input stream (slave), up.ready is registered
//   dn         : output stream (master), dn.shares stable while dn.valid
//   occupancy  : number of buffered entries, 0..2
module prince_affine_share_stage
  import prince_ti_pkg::*;
#(
  parameter int SHARES = DEF_SHARES,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  prince_affine_share_stage_if.slave    up,
  prince_affine_share_stage_if.master   dn,
  output logic [1:0]                    occupancy
);

  localparam int NIB = WIDTH / 4;
  localparam int DW  = SHARES * WIDTH;

  if (WIDTH % 4 != 0) begin : g_width_check
    $error("prince_affine_share_stage: WIDTH must be a multiple of 4");
  end

  logic [DW-1:0] xform;

  for (genvar s = 0; s < SHARES; s++) begin : g_share
    for (genvar n = 0; n < NIB; n++) begin : g_nib
      prince_affine_nibble #(
        .COMPLEMENT (s == 0)
      ) u_nib (
        .x (up.shares[s*WIDTH + n*4 +: 4]),
        .z (xform[s*WIDTH + n*4 +: 4])
      );
    end
  end

  logic          m_valid, s_valid;
  logic [DW-1:0] m_data,  s_data;
  logic          rdy_q;
  logic          do_accept, do_release;
  logic          s_valid_nxt;

  assign do_accept  = up.valid && rdy_q;
  assign do_release = m_valid && dn.ready;

  // Skid occupancy next cycle; ready is registered from it so upstream never
  // sees a combinational path from out_ready.
  assign s_valid_nxt = (s_valid && !do_release) ||
                       (m_valid && !s_valid && do_accept && !do_release);

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      rdy_q   <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      m_data  <= '0;
      s_data  <= '0;
      rdy_q   <= 1'b1;
    end else begin
      if (!m_valid) begin
        if (do_accept) begin
          m_valid <= 1'b1;
          m_data  <= xform;
        end
      end else if (!s_valid) begin
        if (do_accept && do_release) begin
          m_data <= xform;
        end else if (do_accept) begin
          s_valid <= 1'b1;
          s_data  <= xform;
        end else if (do_release) begin
          m_valid <= 1'b0;
        end
      end else if (do_release) begin
        // Skid drains into main; clear it so no stale share lingers.
        m_data  <= s_data;
        s_data  <= '0;
        s_valid <= 1'b0;
      end
      rdy_q <= !s_valid_nxt;
    end
  end

  assign up.ready  = rdy_q;
  assign dn.valid  = m_valid;
  assign dn.shares = m_data;
  assign occupancy = {1'b0, m_valid} + {1'b0, s_valid};

endmodule

// File: tb/tb_prince_affine_share_stage.sv
module tb_prince_affine_share_stage;
  import prince_ti_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] occupancy;

  prince_affine_share_stage_if up_if ();
  prince_affine_share_stage_if dn_if ();

  prince_affine_share_stage dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .up        (up_if),
    .dn        (dn_if),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    state_t sh;
    share_t x;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic state_t mk(input share_t s0, s1, s2, s3, s4);
    return {s4, s3, s2, s1, s0};
  endfunction

  function automatic share_t xor_all(input state_t st);
    share_t r = '0;
    for (int s = 0; s < DEF_SHARES; s++) r ^= share_slice(st, s);
    return r;
  endfunction

  function automatic logic [3:0] a_nib(input logic [3:0] x, input logic c);
    return {x[2], x[3] ^ c, x[0] ^ x[1] ^ x[2], x[1] ^ c};
  endfunction

  function automatic share_t a_share(input share_t x, input logic c);
    share_t r;
    for (int n = 0; n < NIBBLES; n++) r[n*4 +: 4] = a_nib(x[n*4 +: 4], c);
    return r;
  endfunction

  function automatic state_t a_state(input state_t st);
    state_t r;
    for (int s = 0; s < DEF_SHARES; s++)
      r[s*DEF_WIDTH +: DEF_WIDTH] = a_share(share_slice(st, s), s == 0);
    return r;
  endfunction

  // Output monitor: every release must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && !flush && dn_if.valid && dn_if.ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", dn_if.shares, '0);
        if (dn_if.shares === '0) begin
          errors++;
          $display("FAIL unexpected_output: got release expected none");
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_shares", dn_if.shares, e.sh);
        chk("sb_xor", xor_all(dn_if.shares), e.x);
      end
    end
  end

  task automatic send(input state_t d, input state_t e, input share_t ex);
    bit acc = 0;
    up_if.valid  = 1'b1;
    up_if.shares = d;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      if (up_if.ready && !flush && !rst) begin
        sb.push_back('{sh: e, x: ex});
        acc = 1;
      end
      @(posedge clk); #1;
    end
    if (!acc) chk("send_timeout", 0, 1);
    up_if.valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && sb.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  localparam share_t K0 = 64'h0;
  localparam share_t KF = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam share_t K5 = 64'h5555_5555_5555_5555;
  localparam share_t KA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam share_t KC = 64'h0123_4567_89AB_CDEF;
  localparam share_t KC0 = 64'h0231_A89B_4675_ECDF; // A without complement
  localparam share_t KC1 = 64'h5764_FDCE_1320_B98A; // A with complement

  bit done;
  int n_acc;
  state_t hold, st;
  state_t v[3];
  exp_t   ev[3];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    up_if.valid  = 1'b0;
    up_if.shares = '0;
    dn_if.ready  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", up_if.ready, 0);
    chk("rst_out_valid", dn_if.valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_shares", dn_if.shares, '0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", up_if.ready, 1);

    // Test 1-3: directed single transfers
    send(mk(K0, K0, K0, K0, K0), mk(K5, K0, K0, K0, K0), K5);
    chk("t1_out_valid", dn_if.valid, 1);
    chk("t1_occupancy", occupancy, 1);
    chk("t1_share0", share_slice(dn_if.shares, 0), K5);
    chk("t1_xor", xor_all(dn_if.shares), K5);
    dn_if.ready = 1'b1; @(posedge clk); #1; dn_if.ready = 1'b0;

    send(mk(KF, K0, K0, K0, K0), mk(KA, K0, K0, K0, K0), KA);
    chk("t2_share0", share_slice(dn_if.shares, 0), KA);
    dn_if.ready = 1'b1; @(posedge clk); #1; dn_if.ready = 1'b0;

    send(mk(K0, KF, K0, K0, K0), mk(K5, KF, K0, K0, K0), KA);
    chk("t3_share0", share_slice(dn_if.shares, 0), K5);
    chk("t3_share1", share_slice(dn_if.shares, 1), KF);
    chk("t3_xor", xor_all(dn_if.shares), KA);
    dn_if.ready = 1'b1; @(posedge clk); #1; dn_if.ready = 1'b0;

    send(mk(K0, K0, KC, K0, K0), mk(K5, K0, KC0, K0, K0), KC1);
    send(mk(KC, K0, K0, K0, K0), mk(KC1, K0, K0, K0, K0), KC1);
    dn_if.ready = 1'b1;
    drain();
    dn_if.ready = 1'b0;

    // Test 4: random shares with random backpressure
    done = 0;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          for (int w = 0; w < 10; w++) st[w*32 +: 32] = $urandom;
          send(st, a_state(st), a_share(xor_all(st), 1'b1));
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          dn_if.ready = ($urandom_range(0, 99) >= 30);
        end
      end
    join
    dn_if.ready = 1'b1;
    drain();
    dn_if.ready = 1'b0;
    @(posedge clk); #1;

    // Test 5: backpressure, three offers, two accepted
    v[0] = mk(K0, K0, KC, K0, K0); ev[0] = '{sh: mk(K5, K0, KC0, K0, K0), x: KC1};
    v[1] = mk(KC, K0, K0, K0, K0); ev[1] = '{sh: mk(KC1, K0, K0, K0, K0), x: KC1};
    v[2] = mk(K0, K0, K0, KF, K0); ev[2] = '{sh: mk(K5, K0, K0, KF, K0), x: KA};
    n_acc = 0;
    for (int i = 0; i < 3; i++) begin
      up_if.valid  = 1'b1;
      up_if.shares = v[i];
      @(negedge clk);
      if (up_if.ready) begin
        sb.push_back(ev[i]);
        n_acc++;
      end
      @(posedge clk); #1;
    end
    up_if.valid = 1'b0;
    chk("t5_accepted", n_acc, 2);
    chk("t5_occupancy", occupancy, 2);
    chk("t5_in_ready", up_if.ready, 0);
    hold = dn_if.shares;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_stable", dn_if.shares, hold);
    chk("t5_head", dn_if.shares, ev[0].sh);
    dn_if.ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_second_valid", dn_if.valid, 1);
    chk("t5_occ_after1", occupancy, 1);
    @(posedge clk); #1;
    chk("t5_occ_after2", occupancy, 0);
    chk("t5_in_ready_after", up_if.ready, 1);
    dn_if.ready = 1'b0;

    // Test 6a: flush with two entries buffered and a state on offer
    send(mk(KF, K0, K0, K0, K0), mk(KA, K0, K0, K0, K0), KA);
    send(mk(K0, KF, K0, K0, K0), mk(K5, KF, K0, K0, K0), KA);
    chk("t6_occupancy_full", occupancy, 2);
    flush = 1'b1; up_if.valid = 1'b1; up_if.shares = mk(KC, KC, K0, K0, K0);
    @(posedge clk); #1;
    flush = 1'b0; up_if.valid = 1'b0;
    sb.delete();
    chk("t6_out_valid", dn_if.valid, 0);
    chk("t6_occupancy", occupancy, 0);
    chk("t6_out_shares", dn_if.shares, '0);
    chk("t6_in_ready", up_if.ready, 1);

    // Test 6b: flush while empty and ready; offered state must be dropped
    flush = 1'b1; up_if.valid = 1'b1; up_if.shares = mk(KC, K0, KF, K0, K0);
    @(posedge clk); #1;
    flush = 1'b0; up_if.valid = 1'b0;
    chk("t6b_out_valid", dn_if.valid, 0);
    chk("t6b_occupancy", occupancy, 0);
    dn_if.ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("t6b_never_valid", dn_if.valid, 0);
    dn_if.ready = 1'b0;

    // Test 6c: reset with two entries buffered
    send(mk(KF, K0, K0, K0, K0), mk(KA, K0, K0, K0, K0), KA);
    send(mk(K0, KF, K0, K0, K0), mk(K5, KF, K0, K0, K0), KA);
    rst = 1'b1; up_if.valid = 1'b1; up_if.shares = mk(KC, K0, K0, K0, KF);
    @(posedge clk); #1;
    sb.delete();
    chk("t6c_in_ready_rst", up_if.ready, 0);
    chk("t6c_out_valid", dn_if.valid, 0);
    chk("t6c_occupancy", occupancy, 0);
    chk("t6c_out_shares", dn_if.shares, '0);
    @(posedge clk); #1;
    chk("t6c_in_ready_rst2", up_if.ready, 0);
    rst = 1'b0; up_if.valid = 1'b0;
    @(posedge clk); #1;
    chk("t6c_in_ready_after", up_if.ready, 1);
    dn_if.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6c_never_valid", dn_if.valid, 0);
    dn_if.ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
